// File: rtl/z80fi_insn_capture_pkg.sv
// rtl/z80fi_insn_capture_pkg.sv - shared types and helpers for the Z80FI instruction capture block
package z80fi_insn_capture_pkg;

  // Width of a Z80 register selector.
  localparam int REG_W        = 4;
  localparam int INSN_MAX_LEN = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } capture_state_t;

  function automatic logic [31:0] insn_put_byte(input logic [31:0] insn,
                                                input logic [1:0]  pos,
                                                input logic [7:0]  b);
    logic [31:0] r;
    r = insn;
    r[8*pos +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/z80fi_capture_slot.sv
// rtl/z80fi_capture_slot.sv - two-entry fill-in-order slot for register and memory reads
// cur_* shows the slot including this cycle's push so a same-cycle retirement sees it.
module z80fi_capture_slot
  import z80fi_insn_capture_pkg::*;
#(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [KEY_W-1:0] push_key,
  input  logic [VAL_W-1:0] push_val,
  output logic [1:0]       cur_vld,
  output logic [KEY_W-1:0] cur_key0,
  output logic [KEY_W-1:0] cur_key1,
  output logic [VAL_W-1:0] cur_val0,
  output logic [VAL_W-1:0] cur_val1,
  output logic             overflow
);

  logic [1:0]       vld_q;
  logic [KEY_W-1:0] key0_q, key1_q;
  logic [VAL_W-1:0] val0_q, val1_q;

  always_comb begin
    cur_vld  = vld_q;
    cur_key0 = key0_q;
    cur_key1 = key1_q;
    cur_val0 = val0_q;
    cur_val1 = val1_q;
    overflow = 1'b0;
    if (push) begin
      if (!vld_q[0]) begin
        cur_vld[0] = 1'b1;
        cur_key0   = push_key;
        cur_val0   = push_val;
      end else if (!vld_q[1]) begin
        cur_vld[1] = 1'b1;
        cur_key1   = push_key;
        cur_val1   = push_val;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld_q  <= '0;
      key0_q <= '0;
      key1_q <= '0;
      val0_q <= '0;
      val1_q <= '0;
    end else begin
      vld_q  <= cur_vld;
      key0_q <= cur_key0;
      key1_q <= cur_key1;
      val0_q <= cur_val0;
      val1_q <= cur_val1;
    end
  end

endmodule

// File: rtl/z80fi_insn_capture.sv
// rtl/z80fi_insn_capture.sv - gathers Z80 trace events into one registered Z80FI record per retirement
// Optional Z80FI_CAPTURE_ORDER_EN adds the z80fi_order retirement sequence output.
module z80fi_insn_capture
  import z80fi_insn_capture_pkg::*;
#(
  parameter int CHECK_INDEX = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_fetch,
  input  logic [15:0]      ev_fetch_addr,
  input  logic [7:0]       ev_fetch_data,
  input  logic             ev_rrd,
  input  logic [REG_W-1:0] ev_rrd_num,
  input  logic [15:0]      ev_rrd_data,
  input  logic             ev_rwr,
  input  logic [REG_W-1:0] ev_rwr_num,
  input  logic [15:0]      ev_rwr_data,
  input  logic             ev_mrd,
  input  logic             ev_mwr,
  input  logic [15:0]      ev_maddr,
  input  logic [7:0]       ev_mrdata,
  input  logic [7:0]       ev_mwdata,
  input  logic             ev_done,
  input  logic [15:0]      ev_next_pc,
  output logic             z80fi_valid,
`ifdef Z80FI_CAPTURE_ORDER_EN
  output logic [63:0]      z80fi_order,
`endif
  output logic [31:0]      z80fi_insn,
  output logic [2:0]       z80fi_insn_len,
  output logic [15:0]      z80fi_pc_rdata,
  output logic [15:0]      z80fi_pc_wdata,
  output logic             z80fi_reg1_rd,
  output logic [REG_W-1:0] z80fi_reg1_rnum,
  output logic [15:0]      z80fi_reg1_rdata,
  output logic             z80fi_reg2_rd,
  output logic [REG_W-1:0] z80fi_reg2_rnum,
  output logic [15:0]      z80fi_reg2_rdata,
  output logic             z80fi_reg_wr,
  output logic [REG_W-1:0] z80fi_reg_wnum,
  output logic [15:0]      z80fi_reg_wdata,
  output logic             z80fi_mem_rd,
  output logic [15:0]      z80fi_mem_addr,
  output logic [7:0]       z80fi_mem_rdata,
  output logic             z80fi_mem_rd2,
  output logic [15:0]      z80fi_mem_addr2,
  output logic [7:0]       z80fi_mem_rdata2,
  output logic             z80fi_mem_wr,
  output logic [7:0]       z80fi_mem_wdata,
  output logic             check,
  output logic             capture_err
);

  capture_state_t state_q, state_d;

  logic [31:0]      insn_q, insn_d;
  logic [2:0]       len_q, len_d;
  logic [15:0]      pc_q;
  logic             rwr_q, cur_rwr;
  logic [REG_W-1:0] wnum_q, cur_wnum;
  logic [15:0]      wdata_q, cur_wdata;
  logic             mwr_q, cur_mwr;
  logic [15:0]      mwaddr_q, cur_mwaddr;
  logic [7:0]       mwdata_q, cur_mwdata;
  logic             open_rec, emit, err_set, slot_clear;
  logic [CNT_W-1:0] ret_cnt;
`ifdef Z80FI_CAPTURE_ORDER_EN
  logic [63:0]      order_q;
`endif

  logic             r_push, r_ovf;
  logic [1:0]       r_vld;
  logic [REG_W-1:0] r_key0, r_key1;
  logic [15:0]      r_val0, r_val1;
  logic             m_push, m_ovf;
  logic [1:0]       m_vld;
  logic [15:0]      m_key0, m_key1;
  logic [7:0]       m_val0, m_val1;

  assign slot_clear = open_rec | emit;

  z80fi_capture_slot #(.KEY_W(REG_W), .VAL_W(16)) u_rrd_slot (
    .clk(clk), .reset(reset), .clear(slot_clear), .push(r_push),
    .push_key(ev_rrd_num), .push_val(ev_rrd_data),
    .cur_vld(r_vld), .cur_key0(r_key0), .cur_key1(r_key1),
    .cur_val0(r_val0), .cur_val1(r_val1), .overflow(r_ovf)
  );

  z80fi_capture_slot #(.KEY_W(16), .VAL_W(8)) u_mrd_slot (
    .clk(clk), .reset(reset), .clear(slot_clear), .push(m_push),
    .push_key(ev_maddr), .push_val(ev_mrdata),
    .cur_vld(m_vld), .cur_key0(m_key0), .cur_key1(m_key1),
    .cur_val0(m_val0), .cur_val1(m_val1), .overflow(m_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    open_rec   = 1'b0;
    emit       = 1'b0;
    err_set    = 1'b0;
    r_push     = 1'b0;
    m_push     = 1'b0;
    insn_d     = insn_q;
    len_d      = len_q;
    cur_rwr    = rwr_q;
    cur_wnum   = wnum_q;
    cur_wdata  = wdata_q;
    cur_mwr    = mwr_q;
    cur_mwaddr = mwaddr_q;
    cur_mwdata = mwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_rrd || ev_rwr || ev_mrd || ev_mwr || ev_done) err_set = 1'b1;
        if (ev_fetch) begin
          open_rec = 1'b1;
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        r_push = ev_rrd;
        m_push = ev_mrd;
        if (r_ovf || m_ovf) err_set = 1'b1;
        if (ev_rwr) begin
          if (rwr_q) err_set = 1'b1;
          cur_rwr   = 1'b1;
          cur_wnum  = ev_rwr_num;
          cur_wdata = ev_rwr_data;
        end
        if (ev_mwr) begin
          // A read-modify-write must touch a single address.
          if (m_vld[0] && (m_key0 != ev_maddr)) err_set = 1'b1;
          cur_mwr    = 1'b1;
          cur_mwaddr = ev_maddr;
          cur_mwdata = ev_mwdata;
        end
        if (ev_done) begin
          emit = 1'b1;
          if (ev_fetch) open_rec = 1'b1;
          else          state_d  = ST_IDLE;
        end else if (ev_fetch) begin
          if (len_q == 3'(INSN_MAX_LEN)) begin
            err_set = 1'b1;
          end else begin
            insn_d = insn_put_byte(insn_q, len_q[1:0], ev_fetch_data);
            len_d  = len_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      insn_q   <= '0;
      len_q    <= '0;
      pc_q     <= '0;
      rwr_q    <= 1'b0;
      wnum_q   <= '0;
      wdata_q  <= '0;
      mwr_q    <= 1'b0;
      mwaddr_q <= '0;
      mwdata_q <= '0;
    end else if (open_rec) begin
      insn_q <= {24'b0, ev_fetch_data};
      len_q  <= 3'd1;
      pc_q   <= ev_fetch_addr;
      rwr_q  <= 1'b0;
      mwr_q  <= 1'b0;
    end else if (emit) begin
      insn_q <= '0;
      len_q  <= '0;
      rwr_q  <= 1'b0;
      mwr_q  <= 1'b0;
    end else begin
      insn_q   <= insn_d;
      len_q    <= len_d;
      rwr_q    <= cur_rwr;
      wnum_q   <= cur_wnum;
      wdata_q  <= cur_wdata;
      mwr_q    <= cur_mwr;
      mwaddr_q <= cur_mwaddr;
      mwdata_q <= cur_mwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z80fi_valid      <= 1'b0;
      check            <= 1'b0;
      capture_err      <= 1'b0;
      ret_cnt          <= '0;
`ifdef Z80FI_CAPTURE_ORDER_EN
      order_q          <= '0;
      z80fi_order      <= '0;
`endif
      z80fi_insn       <= '0;
      z80fi_insn_len   <= '0;
      z80fi_pc_rdata   <= '0;
      z80fi_pc_wdata   <= '0;
      z80fi_reg1_rd    <= 1'b0;
      z80fi_reg1_rnum  <= '0;
      z80fi_reg1_rdata <= '0;
      z80fi_reg2_rd    <= 1'b0;
      z80fi_reg2_rnum  <= '0;
      z80fi_reg2_rdata <= '0;
      z80fi_reg_wr     <= 1'b0;
      z80fi_reg_wnum   <= '0;
      z80fi_reg_wdata  <= '0;
      z80fi_mem_rd     <= 1'b0;
      z80fi_mem_addr   <= '0;
      z80fi_mem_rdata  <= '0;
      z80fi_mem_rd2    <= 1'b0;
      z80fi_mem_addr2  <= '0;
      z80fi_mem_rdata2 <= '0;
      z80fi_mem_wr     <= 1'b0;
      z80fi_mem_wdata  <= '0;
    end else begin
      z80fi_valid <= emit;
      check       <= emit && (ret_cnt == CNT_W'(CHECK_INDEX));
      capture_err <= capture_err | err_set;
      if (emit) begin
        if (ret_cnt != '1) ret_cnt <= ret_cnt + 1'b1;
`ifdef Z80FI_CAPTURE_ORDER_EN
        order_q     <= order_q + 64'd1;
        z80fi_order <= order_q;
`endif
        z80fi_insn       <= insn_q;
        z80fi_insn_len   <= len_q;
        z80fi_pc_rdata   <= pc_q;
        z80fi_pc_wdata   <= ev_next_pc;
        z80fi_reg1_rd    <= r_vld[0];
        z80fi_reg1_rnum  <= r_key0;
        z80fi_reg1_rdata <= r_val0;
        z80fi_reg2_rd    <= r_vld[1];
        z80fi_reg2_rnum  <= r_key1;
        z80fi_reg2_rdata <= r_val1;
        z80fi_reg_wr     <= cur_rwr;
        z80fi_reg_wnum   <= cur_wnum;
        z80fi_reg_wdata  <= cur_wdata;
        z80fi_mem_rd     <= m_vld[0];
        z80fi_mem_addr   <= cur_mwr ? cur_mwaddr : m_key0;
        z80fi_mem_rdata  <= m_val0;
        z80fi_mem_rd2    <= m_vld[1];
        z80fi_mem_addr2  <= m_key1;
        z80fi_mem_rdata2 <= m_val1;
        z80fi_mem_wr     <= cur_mwr;
        z80fi_mem_wdata  <= cur_mwdata;
      end
    end
  end

endmodule
